serial_adder8: RTL and testbench



---
 rtl/serial_adder8.sv | 99 +++++++++
 tb/tb_serial_adder8.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder8.sv
// serial_adder8 -- bit-serial 8-bit unsigned adder, LSB first.
// One full-adder cell plus a carry flop; 10-cycle issue interval,
// start/busy/done handshake.
// Optional macro SERIAL_ADDER_CIN_EN: adds the Cin port, which is loaded
// into the carry flop when an operation is accepted.
module serial_adder8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
`ifdef SERIAL_ADDER_CIN_EN
    input  logic       Cin,
`endif
    output logic [7:0] S,
    output logic       Cout,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state;
    logic [7:0] a_sr;
    logic [7:0] b_sr;
    logic [7:0] sum_sr;
    logic [2:0] cnt;
    logic       c;
    logic       cin_v;
    logic       s_bit;
    logic       c_nxt;

`ifdef SERIAL_ADDER_CIN_EN
    assign cin_v = Cin;
`else
    assign cin_v = 1'b0;
`endif

    // The single full-adder cell working on the current LSBs.
    assign s_bit = a_sr[0] ^ b_sr[0] ^ c;
    assign c_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);

    // FSM, datapath shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_sr   <= 8'h00;
            b_sr   <= 8'h00;
            sum_sr <= 8'h00;
            cnt    <= 3'd0;
            c      <= 1'b0;
            S      <= 8'h00;
            Cout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        cnt   <= 3'd0;
                        c     <= cin_v;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sr   <= {1'b0, a_sr[7:1]};
                    b_sr   <= {1'b0, b_sr[7:1]};
                    sum_sr <= {s_bit, sum_sr[7:1]};
                    c      <= c_nxt;
                    cnt    <= cnt + 3'd1;
                    // Last bit: publish the full word, bypassing sum_sr so S
                    // is valid on the same edge the final bit is produced.
                    if (cnt == 3'd7) begin
                        S     <= {s_bit, sum_sr[7:1]};
                        Cout  <= c_nxt;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder8.sv
// Scoreboard bench for serial_adder8: stimulus pushes expected {Cout,S},
// a forked monitor pops and compares on every done pulse.
module tb_serial_adder8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic       Cin = 1'b0;
    logic [7:0] S;
    logic       Cout;
    logic       busy;
    logic       done;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_done = -100;
    logic [8:0] expq[$];

    serial_adder8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
`ifdef SERIAL_ADDER_CIN_EN
        .Cin   (Cin),
`endif
        .S     (S),
        .Cout  (Cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic ci);
`ifdef SERIAL_ADDER_CIN_EN
        return {1'b0, a} + {1'b0, b} + {8'h00, ci};
`else
        return {1'b0, a} + {1'b0, b} + 9'h000 * ci;
`endif
    endfunction

    // Wait (bounded) until the DUT is idle; called just after a negedge.
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic ci);
        wait_idle();
        A = a; B = b; Cin = ci; start = 1'b1;
        expq.push_back(model(a, b, ci));
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [9:0] bv;
        logic [9:0] dv;
        logic [19:0] dd;
        fork
            // Monitor: compares each done pulse against the scoreboard.
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    last_done = -100;
                end else if (done) begin
                    chk("done_spacing_ok", 32'(cyc - last_done >= 10), 32'd1);
                    last_done = cyc;
                    if (expq.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        logic [8:0] e;
                        e = expq.pop_front();
                        chk("result", {23'd0, Cout, S}, {23'd0, e});
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_S", 32'(S), 32'h00);
        chk("rst_Cout", 32'(Cout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 0x35+0x1A with timing: busy after E0..E8, done only after E8
        wait_idle();
        A = 8'h35; B = 8'h1A; Cin = 1'b0; start = 1'b1;
        expq.push_back(9'h04F);
        bv = '0; dv = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            bv[i] = busy;
            dv[i] = done;
        end
        chk("busy_window", 32'(bv), 32'h1FF);
        chk("done_timing", 32'(dv), 32'h100);

        issue(8'hFF, 8'h01, 1'b0);
        issue(8'hFF, 8'hFF, 1'b0);
        wait_idle();
        repeat (5) @(negedge clk);
        chk("hold_S", 32'(S), 32'hFE);
        chk("hold_Cout", 32'(Cout), 32'd1);

        // start held through RUN/DONE: second op accepted only at E10
        wait_idle();
        A = 8'h10; B = 8'h20; start = 1'b1;
        expq.push_back(9'h030);
        expq.push_back(9'h002);
        dd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin A = 8'h01; B = 8'h01; end
            dd[i] = done;
            if (i == 18) start = 1'b0;
        end
        chk("held_start_done_cycles", 32'(dd), 32'h40100);

        // Reset mid-RUN (between E4 and E5)
        wait_idle();
        A = 8'h80; B = 8'h80; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_S", 32'(S), 32'h00);
        chk("abort_Cout", 32'(Cout), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_abort_busy", 32'(busy), 32'd0);
        issue(8'h80, 8'h80, 1'b0);

`ifdef SERIAL_ADDER_CIN_EN
        issue(8'h7F, 8'h00, 1'b1);
        issue(8'hFF, 8'h00, 1'b1);
`else
        issue(8'h7F, 8'h00, 1'b0);
`endif

        // Random sweep with random start gaps
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Drain scoreboard
        for (int n = 0; n < 50 && expq.size() != 0; n++) @(negedge clk);
        chk("drain_empty", 32'(expq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
